waveform_generator: RTL and testbench

- Free-running digital waveform generator. Produces one 8-bit unsigned sample per clock, intended to feed a DAC.
- An 8-bit phase accumulator steps once per clock, so every waveform has a period of 256 clocks.
- A 3-bit function select chooses the waveform shape. The phase is shared across all shapes, so switching functions never restarts the period.

---
 rtl/waveform_pkg.sv | 30 +++
 rtl/sine_quarter_lut.sv | 20 ++
 rtl/waveform_generator.sv | 56 +++++
 tb/tb_waveform_generator.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/waveform_pkg.sv
// Shared definitions for the waveform generator: function encodings and the
// quarter-wave sine table Q[k] = round(127*sin(2*pi*k/256)), k = 0..64.
package waveform_pkg;

   localparam int PERIOD = 256;

   typedef enum logic [2:0] {
      FN_SAW_UP    = 3'b000,
      FN_SAW_DOWN  = 3'b001,
      FN_TRIANGLE  = 3'b010,
      FN_SQUARE    = 3'b011,
      FN_SINE      = 3'b100,
      FN_SINE_FULL = 3'b101,
      FN_SINE_HALF = 3'b110,
      FN_IDLE      = 3'b111
   } func_e;

   localparam logic [6:0] Q_TABLE [0:64] = '{
        7'd0,   7'd3,   7'd6,   7'd9,  7'd12,  7'd16,  7'd19,  7'd22,
       7'd25,  7'd28,  7'd31,  7'd34,  7'd37,  7'd40,  7'd43,  7'd46,
       7'd49,  7'd51,  7'd54,  7'd57,  7'd60,  7'd63,  7'd65,  7'd68,
       7'd71,  7'd73,  7'd76,  7'd78,  7'd81,  7'd83,  7'd85,  7'd88,
       7'd90,  7'd92,  7'd94,  7'd96,  7'd98, 7'd100, 7'd102, 7'd104,
      7'd106, 7'd107, 7'd109, 7'd111, 7'd112, 7'd113, 7'd115, 7'd116,
      7'd117, 7'd118, 7'd120, 7'd121, 7'd122, 7'd122, 7'd123, 7'd124,
      7'd125, 7'd125, 7'd126, 7'd126, 7'd126, 7'd127, 7'd127, 7'd127,
      7'd127
   };

endpackage

// File: rtl/sine_quarter_lut.sv
// Combinational signed sine S(p) in -127..127, built from the quarter table by
// mirroring the index in odd quadrants and negating in the lower half period.
module sine_quarter_lut
   import waveform_pkg::*;
(
   input  logic [7:0]        p_i,
   output logic signed [7:0] s_o
);

   logic [6:0] idx;
   logic [6:0] mag;

   always_comb begin
      // Odd quadrants read the table backwards: 64 - offset gives 64..1.
      idx = p_i[6] ? (7'd64 - {1'b0, p_i[5:0]}) : {1'b0, p_i[5:0]};
      mag = Q_TABLE[idx];
      s_o = p_i[7] ? -$signed({1'b0, mag}) : $signed({1'b0, mag});
   end

endmodule

// File: rtl/waveform_generator.sv
// Free-running 8-bit waveform generator: shared 8-bit phase, 256-clock period,
// shape chosen per clock by func; registered output, one clock of latency.
module waveform_generator
   import waveform_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] func,
   output logic [7:0] wave_out
);

   logic [7:0]        phase_q, phase_d;
   logic [7:0]        wave_q, wave_d;
   logic signed [7:0] sine;
   logic [6:0]        sine_mag;
   func_e             fn;

   sine_quarter_lut u_sine (
      .p_i (phase_q),
      .s_o (sine)
   );

   assign fn = func_e'(func);

   always_comb begin
      phase_d  = (phase_q == 8'(PERIOD - 1)) ? 8'd0 : phase_q + 8'd1;
      sine_mag = sine[7] ? 7'(-sine) : sine[6:0];
      wave_d   = 8'd0;
      case (fn)
         FN_SAW_UP:    wave_d = phase_q;
         FN_SAW_DOWN:  wave_d = 8'hFF - phase_q;
         FN_TRIANGLE:  wave_d = phase_q[7] ? 8'hFF - {phase_q[6:0], 1'b0}
                                           : {phase_q[6:0], 1'b0};
         FN_SQUARE:    wave_d = phase_q[7] ? 8'd0 : 8'hFF;
         // Offset-binary: two's-complement S plus 0x80 lands in 1..255.
         FN_SINE:      wave_d = 8'h80 + $unsigned(sine);
         FN_SINE_FULL: wave_d = {sine_mag, 1'b0};
         FN_SINE_HALF: wave_d = phase_q[7] ? 8'd0 : {sine[6:0], 1'b0};
         FN_IDLE:      wave_d = 8'd0;
         default:      wave_d = 8'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         phase_q <= 8'd0;
         wave_q  <= 8'd0;
      end else begin
         phase_q <= phase_d;
         wave_q  <= wave_d;
      end
   end

   assign wave_out = wave_q;

endmodule

// File: tb/tb_waveform_generator.sv
// Bench for waveform_generator: constant vectors, corner-case sequences and
// randomized func/rst traffic against a real-arithmetic model of the shapes.
module tb_waveform_generator;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] func = 3'b000;
   logic [7:0] wave_out;

   int checks = 0;
   int errors = 0;
   int m_phase = 0;
   int m_exp = 0;

   typedef struct {
      string      name;
      logic [2:0] f;
      int         p;
      int         exp;
   } vec_t;

   vec_t vecs[$];
   int   smp[256];

   always #5 clk = ~clk;

   waveform_generator dut (
      .clk      (clk),
      .rst      (rst),
      .func     (func),
      .wave_out (wave_out)
   );

   // Signed sine straight from the math library, mirrored by symmetry of |sin|.
   function automatic int model_s(int p);
      real x;
      int  mag;
      x   = 127.0 * $sin(3.14159265358979 * real'(p % 128) / 128.0);
      mag = $rtoi(x + 0.5);
      return (p < 128) ? mag : -mag;
   endfunction

   function automatic int model_f(int f, int p);
      int s;
      s = model_s(p);
      case (f)
         0: return p;
         1: return 255 - p;
         2: return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
         3: return (p < 128) ? 255 : 0;
         4: return 128 + s;
         5: return (s < 0) ? -2 * s : 2 * s;
         6: return (p < 128) ? 2 * s : 0;
         default: return 0;
      endcase
   endfunction

   // One clock edge: update the model from the inputs seen at that edge,
   // then return on the falling edge where outputs are sampled.
   task automatic cyc();
      if (rst) begin
         m_exp   = 0;
         m_phase = 0;
      end else begin
         m_exp   = model_f(int'(func), m_phase);
         m_phase = (m_phase + 1) % 256;
      end
      @(negedge clk);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc();
      rst = 1'b0;
   endtask

   initial begin
      vecs.push_back('{"saw_up_p0",    3'b000,   0,   0});
      vecs.push_back('{"saw_up_p255",  3'b000, 255, 255});
      vecs.push_back('{"saw_dn_p100",  3'b001, 100, 155});
      vecs.push_back('{"tri_p0",       3'b010,   0,   0});
      vecs.push_back('{"tri_p127",     3'b010, 127, 254});
      vecs.push_back('{"tri_p128",     3'b010, 128, 255});
      vecs.push_back('{"tri_p255",     3'b010, 255,   1});
      vecs.push_back('{"sq_p127",      3'b011, 127, 255});
      vecs.push_back('{"sq_p128",      3'b011, 128,   0});
      vecs.push_back('{"sine_p0",      3'b100,   0, 128});
      vecs.push_back('{"sine_p64",     3'b100,  64, 255});
      vecs.push_back('{"sine_p128",    3'b100, 128, 128});
      vecs.push_back('{"sine_p192",    3'b100, 192,   1});
      vecs.push_back('{"full_p0",      3'b101,   0,   0});
      vecs.push_back('{"full_p64",     3'b101,  64, 254});
      vecs.push_back('{"full_p192",    3'b101, 192, 254});
      vecs.push_back('{"half_p64",     3'b110,  64, 254});
      vecs.push_back('{"half_p192",    3'b110, 192,   0});
      vecs.push_back('{"idle_p50",     3'b111,  50,   0});

      // Reset state, and output pinned at zero while rst stays high.
      cyc();
      check("reset_state", int'(wave_out), 0);
      func = 3'b100;
      for (int i = 0; i < 4; i++) begin
         cyc();
         check("rst_hold", int'(wave_out), 0);
      end

      // Sawtooth over a full period plus the wrap back to zero.
      do_reset();
      func = 3'b000;
      for (int k = 1; k <= 257; k++) begin
         cyc();
         check("saw_up_seq", int'(wave_out), (k - 1) % 256);
      end

      foreach (vecs[i]) begin
         do_reset();
         func = vecs[i].f;
         repeat (vecs[i].p + 1) cyc();
         check(vecs[i].name, int'(wave_out), vecs[i].exp);
      end

      // Sine over one period against the model, then odd symmetry about p=128.
      do_reset();
      func = 3'b100;
      for (int p = 0; p < 256; p++) begin
         cyc();
         smp[p] = int'(wave_out);
         check("sine_model", smp[p], m_exp);
      end
      for (int p = 1; p < 128; p++)
         check("sine_sym", smp[p] + smp[256 - p], 256);

      // Mid-period switch, then idle while the phase keeps advancing.
      do_reset();
      func = 3'b000;
      repeat (100) cyc();
      func = 3'b001;
      cyc();
      check("switch_saw_dn", int'(wave_out), 155);
      func = 3'b111;
      for (int i = 0; i < 10; i++) begin
         cyc();
         check("idle_zero", int'(wave_out), 0);
      end
      func = 3'b000;
      cyc();
      check("resume_saw_up", int'(wave_out), 111);

      // Single-cycle reset in the middle of a sine period.
      do_reset();
      func = 3'b100;
      repeat (37) cyc();
      rst = 1'b1;
      cyc();
      check("midrst_zero", int'(wave_out), 0);
      rst = 1'b0;
      cyc();
      check("midrst_p0", int'(wave_out), 128);
      cyc();
      check("midrst_p1", int'(wave_out), 131);

      // Randomized func every cycle with occasional resets.
      do_reset();
      for (int i = 0; i < 3000; i++) begin
         func = 3'($urandom_range(0, 7));
         rst  = ($urandom_range(0, 49) == 0);
         cyc();
         check("random", int'(wave_out), m_exp);
      end
      rst = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
